// File: rtl/b01_line_driver.sv
// b01_line_driver: transmit side of the two-line serial link feeding a b01
// consumer. Operand pairs are shifted out LSB-first on line1/line2, and the
// consumer's outp/overflw response is collected into a parallel result word.
module b01_line_driver #(
    parameter int WIDTH  = 8,   // operand/result width, 2..32
    parameter int RX_LAT = 1    // consumer response latency in cycles, 0..3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             line1,
    output logic             line2,
    input  logic             outp,
    input  logic             overflw,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    // Counter value k means "this is cycle ck of the word"; LAST is the
    // final sample cycle, after which the word completes.
    localparam int LAST   = WIDTH + RX_LAT;
    localparam int WIN_LO = RX_LAT + 1;
    localparam int CW     = $clog2(LAST + 1);

    localparam logic [CW-1:0] LAST_C  = CW'(LAST);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] WIN_C   = CW'(WIN_LO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic              line1_q, line1_d;
    logic              line2_q, line2_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;
    logic              res_ovf_q, res_ovf_d;

    logic              done;

    // Next-state logic: accept, shift, windowed capture and completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        line1_d     = 1'b0;
        line2_d     = 1'b0;
        shadow_d    = shadow_q;
        ovf_acc_d   = ovf_acc_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;

        done = (state_q != IDLE) && (cnt_q == LAST_C);

        if (state_q == IDLE) begin
            if (in_valid) begin
                // Bit 0 goes straight to the line flops; the remainder
                // waits in the shift registers for c2..cWIDTH.
                state_d   = SHIFT;
                cnt_d     = CW'(1);
                line1_d   = op_a[0];
                line2_d   = op_b[0];
                sh_a_d    = op_a >> 1;
                sh_b_d    = op_b >> 1;
                shadow_d  = '0;
                ovf_acc_d = 1'b0;
            end
        end else begin
            // Response to bit j arrives in cycle c(j+1+RX_LAT).
            if (cnt_q >= WIN_C) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i + WIN_LO)) begin
                        shadow_d[i] = outp;
                    end
                end
                ovf_acc_d = ovf_acc_q | overflw;
            end

            // Lines carry data only through cWIDTH; zero afterwards.
            if ((state_q == SHIFT) && (cnt_q < WIDTH_C)) begin
                line1_d = sh_a_q[0];
                line2_d = sh_b_q[0];
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
            end

            if (done) begin
                // Final sample lands in the same edge that publishes the word.
                state_d     = IDLE;
                cnt_d       = '0;
                res_valid_d = 1'b1;
                res_data_d  = shadow_d;
                res_ovf_d   = ovf_acc_d;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if ((state_q == SHIFT) && (cnt_q == WIDTH_C)) begin
                    state_d = DRAIN;
                end
            end
        end
    end

    // State and output registers; reset discards any in-flight word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            line1_q     <= 1'b0;
            line2_q     <= 1'b0;
            shadow_q    <= '0;
            ovf_acc_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            line1_q     <= line1_d;
            line2_q     <= line2_d;
            shadow_q    <= shadow_d;
            ovf_acc_q   <= ovf_acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign line1     = line1_q;
    assign line2     = line2_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_b01_line_driver.sv
// Directed bench for b01_line_driver: three instances (RX_LAT 0, 1, 3), each
// looped back through a consumer model returning line1^line2 after RX_LAT.
module tb_b01_line_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iv   [3];
    logic       ir   [3];
    logic       l1   [3];
    logic       l2   [3];
    logic       rv   [3];
    logic       rovf [3];
    logic       bz   [3];
    logic [7:0] rd   [3];
    logic [7:0] opa, opb;
    logic       outp0, outp1, outp2;
    logic [2:0] d3;
    logic       ovf1;
    logic       ovf_off;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    b01_line_driver #(.WIDTH(8), .RX_LAT(0)) u_lat0 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .op_a(opa), .op_b(opb), .line1(l1[0]), .line2(l2[0]),
        .outp(outp0), .overflw(ovf_off), .res_valid(rv[0]), .res_data(rd[0]),
        .res_ovf(rovf[0]), .busy(bz[0]));

    b01_line_driver #(.WIDTH(8), .RX_LAT(1)) u_lat1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .op_a(opa), .op_b(opb), .line1(l1[1]), .line2(l2[1]),
        .outp(outp1), .overflw(ovf1), .res_valid(rv[1]), .res_data(rd[1]),
        .res_ovf(rovf[1]), .busy(bz[1]));

    b01_line_driver #(.WIDTH(8), .RX_LAT(3)) u_lat3 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .op_a(opa), .op_b(opb), .line1(l1[2]), .line2(l2[2]),
        .outp(outp2), .overflw(ovf_off), .res_valid(rv[2]), .res_data(rd[2]),
        .res_ovf(rovf[2]), .busy(bz[2]));

    // Consumer models: XOR of the two lines, delayed by 0, 1 and 3 cycles.
    assign outp0 = l1[0] ^ l2[0];
    assign outp2 = d3[2];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outp1 <= 1'b0;
            d3    <= 3'b000;
        end else begin
            outp1 <= l1[1] ^ l2[1];
            d3    <= {d3[1:0], l1[2] ^ l2[2]};
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 3; s++) iv[s] = 1'b1;
            opa  = 8'($urandom);
            opb  = 8'($urandom);
            ovf1 = k[0];
            tick();
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (l1[s] !== 1'b0 || l2[s] !== 1'b0 || ir[s] !== 1'b1 || rv[s] !== 1'b0 ||
                    rd[s] !== 8'h00 || rovf[s] !== 1'b0 || bz[s] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_hold inst=%0d got l1=%b l2=%b rdy=%b rv=%b rd=%h ovf=%b busy=%b exp 0 0 1 0 00 0 0",
                             s, l1[s], l2[s], ir[s], rv[s], rd[s], rovf[s], bz[s]);
                end
            end
        end
        for (int s = 0; s < 3; s++) iv[s] = 1'b0;
        ovf1  = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (rv[s] !== 1'b0 || ir[s] !== 1'b1 || bz[s] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_release inst=%0d got rv=%b rdy=%b busy=%b exp 0 1 0",
                             s, rv[s], ir[s], bz[s]);
                end
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] el1 = 8'b1010_0101;  // line1 c1..c8: 1,0,1,0,0,1,0,1
        logic [7:0] el2 = 8'b0011_1100;  // line2 c1..c8: 0,0,1,1,1,1,0,0
        opa = 8'hA5; opb = 8'h3C; iv[1] = 1'b1;
        checks++;
        if (ir[1] !== 1'b1) begin
            failures++;
            $display("FAIL loop_ready got %b exp 1", ir[1]);
        end
        tick();
        iv[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (k <= 8) begin
                if (l1[1] !== el1[k-1] || l2[1] !== el2[k-1]) begin
                    failures++;
                    $display("FAIL loop_lines c%0d got %b%b exp %b%b", k, l1[1], l2[1], el1[k-1], el2[k-1]);
                end
            end else if (l1[1] !== 1'b0 || l2[1] !== 1'b0) begin
                failures++;
                $display("FAIL loop_lines_idle c%0d got %b%b exp 00", k, l1[1], l2[1]);
            end
            checks++;
            if (rv[1] !== (k == 10) || bz[1] !== (k <= 9)) begin
                failures++;
                $display("FAIL loop_pulse c%0d got rv=%b busy=%b exp %b %b", k, rv[1], bz[1], k == 10, k <= 9);
            end
            if (k == 10) begin
                checks++;
                if (rd[1] !== 8'h99 || rovf[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL loop_data got %h ovf=%b exp 99 0", rd[1], rovf[1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        int         oc [3] = '{5, 1, 11};
        logic       eo [3] = '{1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 3; c++) begin
            opa = 8'hA5; opb = 8'h3C; iv[1] = 1'b1; ovf1 = 1'b0;
            tick();
            iv[1] = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                ovf1 = (k == oc[c]);
                if (k == 10 || k == 12) begin
                    checks++;
                    if (rovf[1] !== eo[c] || rd[1] !== 8'h99 || rv[1] !== (k == 10)) begin
                        failures++;
                        $display("FAIL ovf_window ovf_at=c%0d c%0d got ovf=%b rd=%h rv=%b exp %b 99 %b",
                                 oc[c], k, rovf[1], rd[1], rv[1], eo[c], k == 10);
                    end
                end
                tick();
            end
            ovf1 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wa [3] = '{8'h01, 8'h80, 8'hFF};
        logic [7:0] wb [3] = '{8'hFF, 8'h80, 8'h00};
        logic [7:0] we [3] = '{8'hFE, 8'h00, 8'hFF};
        int idx = 0;
        for (int k = 0; k <= 32; k++) begin
            if (idx < 3) begin
                iv[1] = 1'b1; opa = wa[idx]; opb = wb[idx];
            end else begin
                iv[1] = 1'b0;
            end
            if (k >= 1 && k <= 30) begin
                checks++;
                if (bz[1] !== (k % 10 != 0)) begin
                    failures++;
                    $display("FAIL b2b_busy c%0d got %b exp %b", k, bz[1], k % 10 != 0);
                end
            end
            checks++;
            if (rv[1] !== (k == 10 || k == 20 || k == 30)) begin
                failures++;
                $display("FAIL b2b_pulse c%0d got %b", k, rv[1]);
            end else if (rv[1] === 1'b1) begin
                checks++;
                if (rd[1] !== we[k/10-1]) begin
                    failures++;
                    $display("FAIL b2b_data c%0d got %h exp %h", k, rd[1], we[k/10-1]);
                end
            end
            if (iv[1] && ir[1]) begin
                checks++;
                if (k != idx * 10) begin
                    failures++;
                    $display("FAIL b2b_accept word=%0d got c%0d exp c%0d", idx, k, idx * 10);
                end
                idx++;
            end
            tick();
        end
        iv[1] = 1'b0;
        checks++;
        if (idx != 3) begin
            failures++;
            $display("FAIL b2b_count got %0d exp 3", idx);
        end
    endtask

    task automatic test_reset_mid();
        opa = 8'h01; opb = 8'hFF; iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        for (int k = 1; k < 4; k++) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (l1[1] !== 1'b0 || l2[1] !== 1'b0 || bz[1] !== 1'b0 || ir[1] !== 1'b1 || rd[1] !== 8'h00) begin
            failures++;
            $display("FAIL midreset_now got l=%b%b busy=%b rdy=%b rd=%h exp 00 0 1 00",
                     l1[1], l2[1], bz[1], ir[1], rd[1]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rv[1] !== 1'b0) begin
                failures++;
                $display("FAIL midreset_pulse got %b exp 0", rv[1]);
            end
        end
        reset = 1'b1;
        tick();
        opa = 8'h12; opb = 8'h34; iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (rv[1] !== (k == 10)) begin
                failures++;
                $display("FAIL midreset_next_pulse c%0d got %b", k, rv[1]);
            end
            if (k == 10) begin
                checks++;
                if (rd[1] !== 8'h26 || rovf[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL midreset_next_data got %h ovf=%b exp 26 0", rd[1], rovf[1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_latency(input int sel, input int pulse);
        logic [7:0] el1 = 8'b1010_0101;
        opa = 8'hA5; opb = 8'h3C; iv[sel] = 1'b1;
        tick();
        iv[sel] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k <= 8) begin
                checks++;
                if (l1[sel] !== el1[k-1]) begin
                    failures++;
                    $display("FAIL lat_line inst=%0d c%0d got %b exp %b", sel, k, l1[sel], el1[k-1]);
                end
            end
            checks++;
            if (rv[sel] !== (k == pulse)) begin
                failures++;
                $display("FAIL lat_pulse inst=%0d c%0d got %b exp %b", sel, k, rv[sel], k == pulse);
            end
            if (k == pulse) begin
                checks++;
                if (rd[sel] !== 8'h99) begin
                    failures++;
                    $display("FAIL lat_data inst=%0d got %h exp 99", sel, rd[sel]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) iv[s] = 1'b0;
        opa = 8'h00; opb = 8'h00; ovf1 = 1'b0; ovf_off = 1'b0;
        tick();
        test_reset();
        test_loopback();
        test_overflow();
        test_back_to_back();
        tick();
        test_reset_mid();
        test_latency(0, 9);
        test_latency(2, 12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
